// File: rtl/decoder_scan_n_if.sv
// decoder_scan_n_if: control inputs and decoded outputs of decoder_scan_n.
// The master drives the controls; the slave is the decoder.
interface decoder_scan_n_if #(
   parameter int IN_W    = 3,
   parameter int DWELL_W = 8
);
   logic               en;
   logic               mode;
   logic [IN_W-1:0]    sel;
   logic               load;
   logic [DWELL_W-1:0] dwell;
   logic [IN_W-1:0]    last;
   logic [2**IN_W-1:0] out;
   logic [IN_W-1:0]    idx;
   logic               valid;
   logic               wrap;
   modport master (output en, mode, sel, load, dwell, last, input out, idx, valid, wrap);
   modport slave  (input en, mode, sel, load, dwell, last, output out, idx, valid, wrap);
endinterface

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered IN_W-to-2**IN_W one-hot decoder with direct and self-timed scan modes.
// Define DECODER_SCAN_BLANK_EN to blank out for the first cycle of each scan step after an advance or load.
module decoder_scan_n #(
   parameter int IN_W    = 3,
   parameter int DWELL_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   decoder_scan_n_if.slave bus
);
   localparam int OUT_W = 2**IN_W;
   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

   state_t             r_state, w_next;
   logic [DWELL_W-1:0] r_cnt, w_cnt;
   logic [IN_W-1:0]    r_idx, w_idx, w_adv;
   logic [OUT_W-1:0]   r_out, w_out;
   logic               r_valid, r_wrap;
   logic               w_scan, w_enter, w_step, w_wrap, w_valid, w_blank;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb
      w_next = !bus.en ? IDLE : bus.mode ? SCAN : DIRECT;

   // Entering SCAN shows the current index for a full dwell before the first advance.
   always_comb begin
      w_scan  = w_next == SCAN;
      w_enter = w_scan && r_state != SCAN;
      w_step  = w_scan && !w_enter && !bus.load && r_cnt == bus.dwell;
      w_adv   = (r_idx >= bus.last) ? '0 : r_idx + 1'b1;
      w_idx   = (w_next == IDLE) ? r_idx :
                (!w_scan || bus.load) ? bus.sel :
                w_step ? w_adv : r_idx;
      w_cnt   = (!w_scan || w_enter || bus.load || w_step) ? '0 : r_cnt + 1'b1;
      w_wrap  = w_step && w_adv == '0;
      w_valid = w_next != IDLE;
`ifdef DECODER_SCAN_BLANK_EN
      w_blank = w_scan && (bus.load || w_step);
`else
      w_blank = 1'b0;
`endif
      w_out   = (w_valid && !w_blank) ? ONE << w_idx : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_out   <= w_out;
         r_valid <= w_valid;
         r_wrap  <= w_wrap;
      end

   assign bus.out   = r_out;
   assign bus.idx   = r_idx;
   assign bus.valid = r_valid;
   assign bus.wrap  = r_wrap;
endmodule
